// File: rtl/lift_request_scheduler.sv
// Per-car SCAN lift scheduler: latches floor requests and sequences direction,
// motion and door_open for the car movement model, using floor_sense as feedback.
module lift_request_scheduler #(
  parameter int N_FLOORS      = 4,
  parameter int DOOR_OPEN_REQ = 100,
  parameter bit IDLE_DIR_UP   = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_FLOORS-1:0] req_in,
  input  logic [N_FLOORS-1:0] floor_sense,
  output logic                direction,
  output logic                motion,
  output logic                door_open,
  output logic [N_FLOORS-1:0] current_floor,
  output logic [N_FLOORS-1:0] pending,
  output logic                fault
);
  localparam int TW = (DOOR_OPEN_REQ > 1) ? $clog2(DOOR_OPEN_REQ) : 1;
  localparam logic [N_FLOORS-1:0] ONE = N_FLOORS'(1);
  localparam logic [TW-1:0] T_LAST = TW'(DOOR_OPEN_REQ - 1);

  typedef enum logic [1:0] {IDLE, MOVE, STOP, DOOR} state_t;

  state_t              state_q, state_d;
  logic                dir_d, motion_d, door_d, arrived_q;
  logic [TW-1:0]       timer_q, timer_d;
  logic [N_FLOORS-1:0] clr, below_m, above_m, req_lat;
  logic                fs_onehot, fs_multi, arrival, at_end;
  logic                req_ahead, req_behind, here_pend;

  assign fs_multi   = |(floor_sense & (floor_sense - ONE));
  assign fs_onehot  = (|floor_sense) && !fs_multi;
  assign below_m    = current_floor - ONE;
  assign above_m    = ~(below_m | current_floor);
  assign req_ahead  = direction ? |(pending & above_m) : |(pending & below_m);
  assign req_behind = direction ? |(pending & below_m) : |(pending & above_m);
  assign here_pend  = |(pending & current_floor);
  // The departure floor's contact is ignored until the car has left it.
  assign arrival    = (state_q == MOVE) && fs_onehot && !arrived_q;
  assign at_end     = direction ? floor_sense[N_FLOORS-1] : floor_sense[0];
  // Re-requests for the floor whose door is open only extend the door time.
  assign req_lat    = req_in & ~((state_q == DOOR) ? current_floor : '0);

  always_comb begin
    state_d  = state_q;
    dir_d    = direction;
    motion_d = motion;
    door_d   = door_open;
    timer_d  = timer_q;
    clr      = '0;
    unique case (state_q)
      IDLE: if (!fault) begin
        if (here_pend) begin
          state_d = DOOR;
          door_d  = 1'b1;
          timer_d = '0;
          clr     = current_floor;
        end else if (req_ahead) begin
          state_d  = MOVE;
          motion_d = 1'b1;
        end else if (req_behind) begin
          dir_d = ~direction;
        end
      end
      MOVE: if (arrival && ((|(pending & floor_sense)) || at_end)) begin
        state_d  = STOP;
        motion_d = 1'b0;
      end
      STOP: if (here_pend) begin
        state_d = DOOR;
        door_d  = 1'b1;
        timer_d = '0;
        clr     = current_floor;
      end else begin
        state_d = IDLE;
      end
      DOOR: if (|(req_in & current_floor)) begin
        timer_d = '0;
      end else if (timer_q == T_LAST) begin
        door_d  = 1'b0;
        state_d = IDLE;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    endcase
    // Ambiguous floor contact: halt and park in IDLE until reset.
    if (fs_multi) begin
      state_d  = IDLE;
      motion_d = 1'b0;
      door_d   = 1'b0;
      clr      = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      direction     <= IDLE_DIR_UP;
      motion        <= 1'b0;
      door_open     <= 1'b0;
      current_floor <= ONE;
      pending       <= '0;
      fault         <= 1'b0;
      timer_q       <= '0;
      arrived_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      direction <= dir_d;
      motion    <= motion_d;
      door_open <= door_d;
      timer_q   <= timer_d;
      pending   <= (pending | req_lat) & ~clr;
      if (fs_onehot) current_floor <= floor_sense;
      if (fs_multi) fault <= 1'b1;
      if (state_q == MOVE) begin
        if (floor_sense == '0) arrived_q <= 1'b0;
        else if (arrival) arrived_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_lift_request_scheduler.sv
// Random SCAN batches scored against a floor-order model, plus directed fault,
// reset and latency scenarios; the bench also plays the car movement model.
module tb_lift_request_scheduler;
  localparam int NF = 4;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [NF-1:0] req_in = '0;
  logic [NF-1:0] floor_sense = 4'b0001;
  logic          direction, motion, door_open, fault;
  logic [NF-1:0] current_floor, pending;

  int checks = 0;
  int failures = 0;

  typedef struct {int fl; int dur;} stop_t;
  stop_t exp_q[$];
  int    plan_fl[$];
  int    plan_rr[$];
  int    m_floor = 0;
  bit    m_dir = 1'b1;

  bit car_en = 1'b1;
  bit on_floor = 1'b1;
  int car_pos = 0;
  int car_cnt = 0;
  int car_mv = 1;
  int travel = 3;

  lift_request_scheduler #(.N_FLOORS(NF), .DOOR_OPEN_REQ(D), .IDLE_DIR_UP(1'b1)) dut (
    .clk(clk), .reset(reset), .req_in(req_in), .floor_sense(floor_sense),
    .direction(direction), .motion(motion), .door_open(door_open),
    .current_floor(current_floor), .pending(pending), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Car movement: leaves a floor 3 cycles after motion, travels 2..5 cycles.
  initial forever begin
    @(posedge clk); #1;
    if (car_en && reset) begin
      if (!on_floor) begin
        car_cnt++;
        if (car_cnt >= travel) begin
          car_pos += car_mv;
          on_floor = 1'b1;
          car_cnt = 0;
          floor_sense = NF'(1) << car_pos;
        end
      end else if (motion) begin
        car_cnt++;
        if (car_cnt >= 3) begin
          car_mv = direction ? 1 : -1;
          chk("car_in_shaft", int'(car_pos + car_mv >= 0 && car_pos + car_mv < NF), 1);
          on_floor = 1'b0;
          car_cnt = 0;
          floor_sense = '0;
          travel = int'($urandom_range(2, 5));
        end
      end else begin
        car_cnt = 0;
      end
    end
  end

  // Monitor: invariants every cycle, stop floor and door time per door opening.
  initial begin
    bit in_door, pdir, pmot;
    int dcnt, edur;
    stop_t s;
    in_door = 1'b0; pdir = 1'b1; pmot = 1'b0; dcnt = 0; edur = D;
    forever begin
      @(negedge clk);
      if (!reset) begin
        in_door = 1'b0;
        pmot = 1'b0;
        pdir = direction;
      end else begin
        chk("door_and_motion", int'(door_open && motion), 0);
        if (direction != pdir) chk("dir_change_while_stopped", int'(motion || pmot), 0);
        pdir = direction;
        pmot = motion;
        if (door_open && !in_door) begin
          in_door = 1'b1;
          dcnt = 1;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            edur = D;
            $display("FAIL unexpected_stop: door opened at floor %b, no stop expected", current_floor);
          end else begin
            s = exp_q.pop_front();
            edur = s.dur;
            chk("stop_floor", int'(current_floor), 1 << s.fl);
            chk("stop_pending_cleared", int'(pending[s.fl]), 0);
          end
        end else if (door_open) begin
          dcnt++;
        end else if (in_door) begin
          in_door = 1'b0;
          chk("door_duration", dcnt, edur);
        end
      end
    end
  end

  // SCAN reference: current floor first, then ahead nearest-first, then behind.
  task automatic plan_batch(input logic [NF-1:0] s);
    bit behind;
    behind = 1'b0;
    plan_fl.delete();
    if (s[m_floor]) plan_fl.push_back(m_floor);
    if (m_dir) begin
      for (int i = m_floor + 1; i < NF; i++) if (s[i]) plan_fl.push_back(i);
      for (int i = m_floor - 1; i >= 0; i--) if (s[i]) begin plan_fl.push_back(i); behind = 1'b1; end
    end else begin
      for (int i = m_floor - 1; i >= 0; i--) if (s[i]) plan_fl.push_back(i);
      for (int i = m_floor + 1; i < NF; i++) if (s[i]) begin plan_fl.push_back(i); behind = 1'b1; end
    end
    if (plan_fl.size() > 0) m_floor = plan_fl[plan_fl.size() - 1];
    if (behind) m_dir = !m_dir;
  endtask

  task automatic push_stop(input int fl, input int rr);
    stop_t st;
    st.fl = fl;
    st.dur = (rr < 0) ? D : rr + 1 + D;
    exp_q.push_back(st);
  endtask

  // Waits for the door at floor fl; optionally re-requests it at timer count rr.
  task automatic serve_stop(input int rr, input int fl);
    int n;
    n = 0;
    while (!door_open && n < 600) begin @(negedge clk); n++; end
    if (!door_open) begin
      checks++;
      failures++;
      $display("FAIL stop_timeout: no door at floor %0d within %0d cycles", fl, n);
      return;
    end
    if (rr >= 0) begin
      repeat (rr) @(negedge clk);
      req_in = NF'(1) << fl;
      @(negedge clk);
      req_in = '0;
    end
    n = 0;
    while (door_open && n < 100) begin @(negedge clk); n++; end
  endtask

  task automatic batch_end();
    repeat (4) @(negedge clk);
    chk("batch_all_served", exp_q.size(), 0);
    exp_q.delete();
    chk("batch_pending_empty", int'(pending), 0);
    chk("batch_final_floor", int'(current_floor), 1 << m_floor);
    chk("batch_final_dir", int'(direction), int'(m_dir));
  endtask

  task automatic run_batch(input logic [NF-1:0] s);
    int rr;
    plan_batch(s);
    plan_rr.delete();
    foreach (plan_fl[i]) begin
      rr = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, D - 1)) : -1;
      push_stop(plan_fl[i], rr);
      plan_rr.push_back(rr);
    end
    @(negedge clk); req_in = s;
    @(negedge clk); req_in = '0;
    foreach (plan_fl[i]) serve_stop(plan_rr[i], plan_fl[i]);
    batch_end();
  endtask

  // Sends the car away from its floor and returns once it is between floors.
  task automatic depart_and_wait(output bit ok);
    int n;
    n = 0;
    @(negedge clk); req_in = NF'(1) << ((m_floor == 0) ? 3 : 0);
    @(negedge clk); req_in = '0;
    while (!(motion && floor_sense == '0) && n < 200) begin @(negedge clk); n++; end
    ok = motion && floor_sense == '0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL depart_timeout: car not between floors after %0d cycles", n);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_direction"}, int'(direction), 1);
    chk({tag, "_motion"}, int'(motion), 0);
    chk({tag, "_door"}, int'(door_open), 0);
    chk({tag, "_floor"}, int'(current_floor), 1);
    chk({tag, "_pending"}, int'(pending), 0);
    chk({tag, "_fault"}, int'(fault), 0);
  endtask

  initial begin
    bit ok;
    int n, k;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b1;

    // Request at the floor the car is parked on: door two cycles later.
    push_stop(0, -1);
    @(negedge clk); req_in = 4'b0001;
    @(negedge clk); req_in = '0;
    chk("here_door_after_1", int'(door_open), 0);
    @(negedge clk);
    chk("here_door_after_2", int'(door_open), 1);
    chk("here_motion", int'(motion), 0);
    serve_stop(-1, 0);
    batch_end();

    for (int b = 0; b < 10; b++) run_batch(NF'($urandom_range(1, 15)));

    // Request added mid-travel ahead of the car, then top-floor arrival latency.
    run_batch(4'b0001);
    m_floor = 3;
    m_dir = 1'b1;
    push_stop(2, -1);
    push_stop(3, -1);
    @(negedge clk); req_in = 4'b1000;
    @(negedge clk); req_in = '0;
    n = 0;
    while (!(car_pos == 1 && !on_floor && car_mv == 1) && n < 300) begin @(negedge clk); n++; end
    chk("midtravel_reached", int'(car_pos == 1 && !on_floor), 1);
    req_in = 4'b0100;
    @(negedge clk); req_in = '0;
    serve_stop(-1, 2);
    n = 0;
    while (!floor_sense[3] && n < 300) begin @(negedge clk); n++; end
    chk("top_arrival_motion_k", int'(motion), 1);
    @(negedge clk);
    chk("top_arrival_motion_k1", int'(motion), 0);
    chk("top_arrival_door_k1", int'(door_open), 0);
    @(negedge clk);
    chk("top_arrival_door_k2", int'(door_open), 1);
    serve_stop(-1, 3);
    batch_end();
    run_batch(4'b0001);

    // Asynchronous reset while travelling between floors.
    depart_and_wait(ok);
    k = car_pos + car_mv;
    car_en = 1'b0;
    #2 reset = 1'b0;
    #1 chk_reset_vals("midmove_reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("relearn_hold", int'(current_floor), 1);
    if (k < 0 || k >= NF) k = 2;
    floor_sense = NF'(1) << k;
    @(negedge clk);
    chk("relearn_floor", int'(current_floor), 1 << k);
    car_pos = k; on_floor = 1'b1; car_cnt = 0; car_en = 1'b1;
    m_floor = k;
    m_dir = 1'b1;

    for (int b = 0; b < 4; b++) run_batch(NF'($urandom_range(1, 15)));

    // Two floor contacts at once: sticky fault, car halted until reset.
    depart_and_wait(ok);
    car_en = 1'b0;
    floor_sense = 4'b0110;
    @(negedge clk);
    chk("fault_set", int'(fault), 1);
    chk("fault_motion", int'(motion), 0);
    floor_sense = '0;
    for (int r = 0; r < 3; r++) begin
      req_in = NF'($urandom_range(1, 15));
      @(negedge clk); req_in = '0;
      repeat (5) @(negedge clk);
      chk("fault_hold_motion", int'(motion), 0);
      chk("fault_hold_door", int'(door_open), 0);
      chk("fault_sticky", int'(fault), 1);
    end
    exp_q.delete();
    #2 reset = 1'b0;
    #1 chk_reset_vals("fault_reset");
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset_fault", int'(fault), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
